// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: generates register write enables and bubble
// flushes for a five-stage pipeline. It handles exceptions, data-memory
// freezes, multi-cycle mul/div, taken branches, load-use hazards and fetch stalls.
module pipe_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic        dmem_rdy,
  input  logic        ex_mul_start,
  input  logic        ex_div_start,
  input  logic        br_taken,
  input  logic        load_use_hz,
  input  logic        imem_rdy,
  output logic        pc_wr,
  output logic        if_id_wr,
  output logic        id_ex_wr,
  output logic        ex_mem_wr,
  output logic        mem_wb_wr,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned STALL_W = 16;

  localparam logic [CNT_W-1:0]   MUL_LOAD  = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0]   DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

  typedef enum logic {
    RUN    = 1'b0,
    MDWAIT = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // State and remaining-latency counter; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and combinational enables/flushes, highest-priority hazard first.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_wr        = 1'b0;
    if_id_wr     = 1'b0;
    id_ex_wr     = 1'b0;
    ex_mem_wr    = 1'b0;
    mem_wb_wr    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    md_done      = 1'b0;
    if (rst_n) begin
      md_busy = (state_q == MDWAIT);
      if (exc_req) begin
        // Flush everything younger than WB and redirect fetch; abort mul/div.
        pc_wr        = 1'b1;
        if_id_wr     = 1'b1;
        id_ex_wr     = 1'b1;
        ex_mem_wr    = 1'b1;
        mem_wb_wr    = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        state_d      = RUN;
        cnt_d        = '0;
      end else if (!dmem_rdy) begin
        // Whole pipeline frozen: everything is held at its default value.
        state_d = state_q;
      end else if (state_q == MDWAIT) begin
        if (cnt_q > CNT_ONE) begin
          ex_mem_wr    = 1'b1;
          mem_wb_wr    = 1'b1;
          ex_mem_flush = 1'b1;
          cnt_d        = cnt_q - CNT_ONE;
        end else begin
          pc_wr     = 1'b1;
          if_id_wr  = 1'b1;
          id_ex_wr  = 1'b1;
          ex_mem_wr = 1'b1;
          mem_wb_wr = 1'b1;
          md_done   = 1'b1;
          state_d   = RUN;
          cnt_d     = '0;
        end
      end else if (ex_div_start || ex_mul_start) begin
        // Start cycle counts toward latency, so load LAT-1 remaining cycles.
        ex_mem_wr    = 1'b1;
        mem_wb_wr    = 1'b1;
        ex_mem_flush = 1'b1;
        cnt_d        = ex_div_start ? DIV_LOAD : MUL_LOAD;
        state_d      = MDWAIT;
      end else if (br_taken) begin
        pc_wr       = 1'b1;
        if_id_wr    = 1'b1;
        id_ex_wr    = 1'b1;
        ex_mem_wr   = 1'b1;
        mem_wb_wr   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use_hz) begin
        id_ex_wr    = 1'b1;
        ex_mem_wr   = 1'b1;
        mem_wb_wr   = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_rdy) begin
        if_id_wr    = 1'b1;
        id_ex_wr    = 1'b1;
        ex_mem_wr   = 1'b1;
        mem_wb_wr   = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_wr     = 1'b1;
        if_id_wr  = 1'b1;
        id_ex_wr  = 1'b1;
        ex_mem_wr = 1'b1;
        mem_wb_wr = 1'b1;
      end
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (!pc_wr && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + STALL_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random
// traffic, all compared against an operation-position reference model.
module tb_pipe_ctrl;

  localparam int MUL_L = 4;
  localparam int DIV_L = 32;

  logic        clk;
  logic        rst_n;
  logic        exc_req;
  logic        dmem_rdy;
  logic        ex_mul_start;
  logic        ex_div_start;
  logic        br_taken;
  logic        load_use_hz;
  logic        imem_rdy;
  logic        pc_wr;
  logic        if_id_wr;
  logic        id_ex_wr;
  logic        ex_mem_wr;
  logic        mem_wb_wr;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_cycles;

  int total;
  int bad;

  // Reference model: whether a mul/div is in flight, its latency, and the
  // 0-based index of the current cycle within the operation.
  bit m_busy;
  int m_lat;
  int m_pos;
  int m_stall;

  logic [9:0] o_vec;

  pipe_ctrl #(.MUL_LAT(MUL_L), .DIV_LAT(DIV_L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exc_req      (exc_req),
    .dmem_rdy     (dmem_rdy),
    .ex_mul_start (ex_mul_start),
    .ex_div_start (ex_div_start),
    .br_taken     (br_taken),
    .load_use_hz  (load_use_hz),
    .imem_rdy     (imem_rdy),
    .pc_wr        (pc_wr),
    .if_id_wr     (if_id_wr),
    .id_ex_wr     (id_ex_wr),
    .ex_mem_wr    (ex_mem_wr),
    .mem_wb_wr    (mem_wb_wr),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // {busy, done, pc, if_id, id_ex, ex_mem, mem_wb, if_fl, id_fl, ex_fl}
  function automatic logic [9:0] obs_vec();
    return {md_busy, md_done, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
            if_id_flush, id_ex_flush, ex_mem_flush};
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [4:0] wr;
    logic [2:0] fl;
    logic       busy;
    logic       done;
    wr = 5'b00000;
    fl = 3'b000;
    busy = 1'b0;
    done = 1'b0;
    if (rst_n) begin
      busy = m_busy;
      if (exc_req) begin
        wr = 5'b11111;
        fl = 3'b111;
      end else if (!dmem_rdy) begin
        wr = 5'b00000;
      end else if (m_busy && (m_pos == m_lat - 1)) begin
        wr = 5'b11111;
        done = 1'b1;
      end else if (m_busy || ex_mul_start || ex_div_start) begin
        wr = 5'b00011;
        fl = 3'b001;
      end else if (br_taken) begin
        wr = 5'b11111;
        fl = 3'b110;
      end else if (load_use_hz) begin
        wr = 5'b00111;
        fl = 3'b010;
      end else if (!imem_rdy) begin
        wr = 5'b01111;
        fl = 3'b100;
      end else begin
        wr = 5'b11111;
      end
    end
    return {busy, done, wr, fl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one rising edge using the inputs held during it.
  task automatic model_update(input logic [9:0] e);
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_stall = 0;
    end else begin
      if (!e[7] && (m_stall < 65535)) m_stall++;
      if (exc_req) begin
        m_busy = 1'b0;
      end else if (dmem_rdy) begin
        if (m_busy) begin
          if (m_pos == m_lat - 1) m_busy = 1'b0;
          else m_pos++;
        end else if (ex_div_start || ex_mul_start) begin
          m_busy = 1'b1;
          m_pos  = 1;
          m_lat  = ex_div_start ? DIV_L : MUL_L;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check before posedge, update model, return to negedge.
  task automatic step(input string tag, input logic e, input logic d, input logic mu,
                      input logic dv, input logic b, input logic l, input logic im);
    logic [9:0] ev;
    exc_req      = e;
    dmem_rdy     = d;
    ex_mul_start = mu;
    ex_div_start = dv;
    br_taken     = b;
    load_use_hz  = l;
    imem_rdy     = im;
    #1;
    ev    = exp_vec();
    o_vec = obs_vec();
    chk({tag, "/out"}, 32'(o_vec), 32'(ev));
    chk({tag, "/stall"}, 32'(stall_cycles), 32'(m_stall));
    @(posedge clk);
    model_update(ev);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int n_busy;
    int n_pclow;
    int done_at;
    int s0;
    total = 0;
    bad = 0;
    m_busy = 1'b0;
    m_lat = MUL_L;
    m_pos = 0;
    m_stall = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    exc_req = 1'b0;
    dmem_rdy = 1'b1;
    ex_mul_start = 1'b0;
    ex_div_start = 1'b0;
    br_taken = 1'b0;
    load_use_hz = 1'b0;
    imem_rdy = 1'b1;

    // Reset state
    #1;
    chk("reset_out", 32'(obs_vec()), 32'd0);
    chk("reset_stall", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    chk("reset_out_edge", 32'(obs_vec()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    idle("idle0");
    idle("idle1");

    // Individual hazards in RUN and the branch-override case
    step("br_lu_imem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("br_override_pc_fl", 32'({o_vec[7], o_vec[2], o_vec[1]}), 32'h7);
    step("lu", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("imem", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("br", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step("exc_run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("dmem_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Divide occupancy: 31 busy cycles, done on the 32nd, 31 stalls
    n_busy = 0;
    n_pclow = 0;
    done_at = 0;
    s0 = int'(stall_cycles);
    step("div_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    if (o_vec[9]) n_busy++;
    if (!o_vec[7]) n_pclow++;
    for (int i = 2; i <= 40; i++) begin
      step("div_wait", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (i == 2) begin
        // Starts while busy are ignored; later cycles go idle again.
        ex_mul_start = 1'b0;
      end
      if (o_vec[9]) n_busy++;
      if (!o_vec[7]) n_pclow++;
      if (o_vec[8] && (done_at == 0)) done_at = i;
      if (i >= 3) idle("div_tail");
      if (i >= 3) break;
    end
    for (int i = 0; i < 40 && m_busy; i++) begin
      idle("div_run");
    end
    // Recount cleanly with idle inputs only
    idle("gap");
    n_busy = 0;
    n_pclow = 0;
    done_at = 0;
    s0 = int'(stall_cycles);
    step("div2_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    if (o_vec[9]) n_busy++;
    if (!o_vec[7]) n_pclow++;
    for (int i = 2; i <= 40; i++) begin
      idle("div2_wait");
      if (o_vec[9]) n_busy++;
      if (!o_vec[7]) n_pclow++;
      if (o_vec[8] && (done_at == 0)) done_at = i;
    end
    chk("div_busy_cycles", 32'(n_busy), 32'd31);
    chk("div_pclow_cycles", 32'(n_pclow), 32'd31);
    chk("div_done_cycle", 32'(done_at), 32'd32);
    chk("div_stall_delta", 32'(int'(stall_cycles) - s0), 32'd31);

    // Multiply frozen at cnt=2 by dmem_rdy low for three cycles
    step("mul_start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle("mul_cnt3");
    for (int i = 0; i < 3; i++) begin
      step("mul_freeze", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("mul_freeze_wr", 32'(o_vec[7:3]), 32'd0);
      chk("mul_freeze_busy", 32'({o_vec[9], o_vec[8]}), 32'h2);
    end
    idle("mul_cnt2");
    chk("mul_not_done_yet", 32'(o_vec[8]), 32'd0);
    idle("mul_cnt1");
    chk("mul_done_2nd", 32'({o_vec[8], o_vec[7:3]}), 32'h3F);
    idle("mul_after");
    chk("mul_after_busy", 32'(o_vec[9]), 32'd0);

    // Exception during divide at cnt=10
    step("div3_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 21; i++) idle("div3_wait");
    step("div3_exc", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("exc_md_pc_fl_done", 32'({o_vec[8], o_vec[7], o_vec[2:0]}), 32'h0F);
    idle("exc_after");
    chk("exc_after_busy", 32'(o_vec[9]), 32'd0);

    // Asynchronous reset mid-divide
    step("div4_start", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) idle("div4_wait");
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out", 32'(obs_vec()), 32'd0);
    chk("areset_stall", 32'(stall_cycles), 32'd0);
    model_update(10'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_reset");
    chk("post_reset_wr", 32'({o_vec[9], o_vec[7:3]}), 32'h1F);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step("rand",
           1'($urandom_range(0, 99) < 5),
           1'($urandom_range(0, 99) >= 15),
           1'($urandom_range(0, 99) < 12),
           1'($urandom_range(0, 99) < 6),
           1'($urandom_range(0, 99) < 15),
           1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) >= 20));
    end
    step("rand_exc_clear", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Long load-use stall saturates the counter
    for (int i = 0; i < 70000; i++) begin
      step("lu_long", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    chk("stall_saturate", 32'(stall_cycles), 32'd65535);
    idle("sat_idle");
    chk("stall_hold", 32'(stall_cycles), 32'd65535);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MUL_LAT, default 4: multiply latency in cycles; legal range 2..63.
REQ-002 SHALL have parameter DIV_LAT, default 32: divide latency in cycles; legal range 2..63.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port exc_req  in  1  exception taken; flush the pipeline.
REQ-006 SHALL have port dmem_rdy  in  1  data memory ready; low means freeze.
REQ-007 SHALL have port ex_mul_start, ex_div_start  in  1 each  multi-cycle operation in EX.
REQ-008 SHALL have port br_taken  in  1  branch resolved taken in EX.
REQ-009 SHALL have port load_use_hz  in  1  ID depends on a load in EX.
REQ-010 SHALL have port imem_rdy  in  1  instruction fetch ready.
REQ-011 SHALL have ports pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out  1 each  pipeline register write enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load NOP (bubble).
REQ-013 SHALL have port md_busy  out  1  state is MDWAIT.
REQ-014 SHALL have port md_done  out  1  last cycle of a multi-cycle operation.
REQ-015 SHALL have port stall_cycles  out  16  saturating count of cycles with pc_wr=0.

Function
REQ-016 SHALL implement FSM states RUN and MDWAIT, plus a 6-bit down-counter cnt.
REQ-017 SHALL compute all enable and flush outputs combinationally from state, cnt and inputs; state, cnt and stall_cycles SHALL be registered.
REQ-018 SHALL drive the corresponding *_wr high whenever any *_flush is high.
REQ-019 SHALL apply this priority in RUN: exc_req > !dmem_rdy > md start > br_taken > load_use_hz > !imem_rdy > normal.
REQ-020 RUN, normal: all five *_wr=1; all flushes=0.
REQ-021 exc_req, any state: pc_wr=1; all three flushes=1; mem_wb_wr=1; next state RUN; cnt cleared; any pending mul/div aborted with no md_done.
REQ-022 !dmem_rdy, any state, no exc_req: all *_wr=0; all flushes=0; state and cnt held.
REQ-023 Md start in RUN: ex_div_start has precedence if both start inputs are high; cnt <= LAT-1; next state MDWAIT; pc_wr, if_id_wr, id_ex_wr=0; ex_mem_flush=1; mem_wb_wr=1.
REQ-024 MDWAIT with cnt>1: same outputs as REQ-023; cnt decrements; start inputs are ignored.
REQ-025 MDWAIT with cnt==1: md_done=1; all *_wr=1; next state RUN; cnt <= 0. Total occupancy is exactly LAT cycles, including the start cycle.
REQ-026 br_taken: all *_wr=1; if_id_flush=1; id_ex_flush=1. br_taken overrides load_use_hz and !imem_rdy.
REQ-027 load_use_hz: pc_wr=0; if_id_wr=0; id_ex_flush=1; ex_mem_wr=1; mem_wb_wr=1.
REQ-028 !imem_rdy: pc_wr=0; if_id_flush=1; remaining *_wr=1.
REQ-029 stall_cycles SHALL increment on every cycle with pc_wr=0 and saturate at 16'hFFFF with no wrap.
REQ-030 md_busy SHALL equal (state==MDWAIT).

Reset
REQ-031 While rst_n=0: state=RUN, cnt=0, stall_cycles=0, all *_wr=0, all flushes=0, md_busy=0, md_done=0.
REQ-032 Assertion of rst_n mid-MDWAIT SHALL abort the operation immediately; the first cycle after release SHALL behave per REQ-020 when inputs are idle.

Verification
REQ-033 Bench SHALL cover: ex_div_start=1 in one cycle, DIV_LAT=32 -> md_busy high 31 cycles, md_done on the 32nd cycle, pc_wr low 31 cycles, stall_cycles=31.
REQ-034 Bench SHALL cover: MUL in flight (cnt=2), dmem_rdy=0 for 3 cycles -> all *_wr=0 and cnt held at 2; md_done 2 cycles after dmem_rdy rises.
REQ-035 Bench SHALL cover: exc_req during MDWAIT at cnt=10 -> same cycle three flushes=1 and pc_wr=1, no md_done, next state RUN.
REQ-036 Bench SHALL cover: br_taken=1 with load_use_hz=1 and imem_rdy=0 -> pc_wr=1, if_id_flush=1, id_ex_flush=1.
REQ-037 Bench SHALL cover: load_use_hz=1 held 70000 cycles -> stall_cycles sticks at 65535.
REQ-038 Bench SHALL cover: rst_n low mid-MDWAIT -> outputs per REQ-031 asynchronously; after release with idle inputs, all *_wr=1.
